// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit. Turns the EX/MEM memory-control
//            bundle into a req/ack transaction with a variable-latency data
//            memory, steers byte lanes for stores, extends load data, and
//            stalls the pipeline until the access completes.
// Ports    : clk, rst (sync, active-high)
//            MemRead_in, MemWrite_in, Load_in[2:0], Store_in[1:0],
//            ALUResult_in[31:0] (byte addr), MemWriteData_in[31:0]
//            dmem_req, dmem_we, dmem_addr[31:0], dmem_be[3:0],
//            dmem_wdata[31:0] (all registered); dmem_rdata[31:0], dmem_ack
//            LoadData_o[31:0], MEM_Stall, AdE_o
// Config   : define MEM_ALIGN_CHECK_EN to raise AdE_o on misaligned
//            half/word accesses; otherwise AdE_o is 0 and accesses are
//            force-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  Load_in,
  input  logic [1:0]  Store_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] MemWriteData_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] LoadData_o,
  output logic        MEM_Stall,
  output logic        AdE_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;

  logic [1:0]  a;
  logic        byte_op;
  logic        half_op;
  logic        go;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_d;

  assign a = ALUResult_in[1:0];

  // Access size; a simultaneous read+write is treated as a read.
  always_comb begin
    byte_op = 1'b0;
    half_op = 1'b0;
    if (MemRead_in) begin
      byte_op = (Load_in == 3'b001) || (Load_in == 3'b010);
      half_op = (Load_in == 3'b011) || (Load_in == 3'b100);
    end else begin
      byte_op = (Store_in == 2'b01);
      half_op = (Store_in == 2'b10);
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic word_op;
  assign word_op = ~byte_op & ~half_op;
  assign AdE_o   = (MemRead_in | MemWrite_in) &
                   ((half_op & a[0]) | (word_op & (a != 2'b00)));
`else
  assign AdE_o = 1'b0;
`endif

  assign go = (MemRead_in | MemWrite_in) & ~AdE_o;

  // Store lane steering: data is replicated across lanes so the memory only
  // needs the byte enables to pick the right bytes.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (!MemRead_in) begin
      if (byte_op) begin
        be_d    = 4'b0001 << a;
        wdata_d = {4{MemWriteData_in[7:0]}};
      end else if (half_op) begin
        be_d    = a[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{MemWriteData_in[15:0]}};
      end else begin
        wdata_d = MemWriteData_in;
      end
    end
  end

  // Load lane select and extension, evaluated against the acked read data.
  always_comb begin
    case (a)
      2'd0:    rbyte = dmem_rdata[7:0];
      2'd1:    rbyte = dmem_rdata[15:8];
      2'd2:    rbyte = dmem_rdata[23:16];
      default: rbyte = dmem_rdata[31:24];
    endcase
    rhalf = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (Load_in)
      3'b001:  load_d = {{24{rbyte[7]}}, rbyte};
      3'b010:  load_d = {24'h0, rbyte};
      3'b011:  load_d = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_d = {16'h0, rhalf};
      default: load_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      load_q  <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_BUSY;
            req_q   <= 1'b1;
            we_q    <= MemWrite_in & ~MemRead_in;
            addr_q  <= {ALUResult_in[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            if (!we_q) begin
              load_q <= load_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall starts combinationally in IDLE so EX/MEM holds the op from the
  // very first cycle; it drops in DONE so the pipeline advances there.
  assign MEM_Stall  = ((state_q == ST_IDLE) & go) | (state_q == ST_BUSY);

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign LoadData_o = load_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit. A cycle
//            timeline model (expected stall/req/fields/load) is checked on
//            every negative edge; literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in;
  logic [2:0]  Load_in;
  logic [1:0]  Store_in;
  logic [31:0] ALUResult_in, MemWriteData_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, LoadData_o;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        MEM_Stall, AdE_o;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Load_in(Load_in), .Store_in(Store_in),
    .ALUResult_in(ALUResult_in), .MemWriteData_in(MemWriteData_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .LoadData_o(LoadData_o), .MEM_Stall(MEM_Stall), .AdE_o(AdE_o)
  );

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_ade, e_we;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_be;

  int          nr, ns;
  logic [31:0] ca, cw;
  logic [3:0]  cb;
  logic        cwe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int op_size(input logic rd, input logic [2:0] ld, input logic [1:0] st);
    if (rd) begin
      if (ld == 3'd1 || ld == 3'd2) return 1;
      if (ld == 3'd3 || ld == 3'd4) return 2;
      return 4;
    end
    if (st == 2'd1) return 1;
    if (st == 2'd2) return 2;
    return 4;
  endfunction

  function automatic logic model_ade(input logic rd, input logic wr, input logic [2:0] ld,
                                     input logic [1:0] st, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    int sz;
    if (!(rd | wr)) return 1'b0;
    sz = op_size(rd, ld, st);
    return ((addr % 32'(sz)) != 0);
`else
    return 1'b0 & rd & wr & (ld == 3'd0) & (st == 2'd0) & (addr == 32'd0);
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic rd, input logic [2:0] ld,
                                          input logic [1:0] st, input logic [31:0] addr);
    int sz = op_size(rd, ld, st);
    int off = int'(addr % 4);
    if (rd || sz == 4) return 4'hF;
    if (sz == 1) return 4'(1 << off);
    return (off >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] model_wdata(input logic rd, input logic [1:0] st,
                                              input logic [31:0] d);
    int sz = op_size(1'b0, 3'd0, st);
    if (rd) return 32'h0;
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] ld, input logic [31:0] addr,
                                            input logic [31:0] r);
    int sz = op_size(1'b1, ld, 2'd0);
    int off = int'(addr % 4);
    logic [31:0] v;
    if (sz == 1) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (ld == 3'd1 && v >= 32'h80) v = v | 32'hFFFFFF00;
      return v;
    end
    if (sz == 2) begin
      v = (r >> (16 * (off / 2))) & 32'hFFFF;
      if (ld == 3'd3 && v >= 32'h8000) v = v | 32'hFFFF0000;
      return v;
    end
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(MEM_Stall), 32'(e_stall));
      check("req",   32'(dmem_req),  32'(e_req));
      check("ade",   32'(AdE_o),     32'(e_ade));
      check("load",  LoadData_o,     e_ld);
      if (e_req) begin
        check("we",    32'(dmem_we), 32'(e_we));
        check("addr",  dmem_addr,    e_addr);
        check("be",    32'(dmem_be), 32'(e_be));
        check("wdata", dmem_wdata,   e_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic go_idle();
    MemRead_in = 1'b0; MemWrite_in = 1'b0; Load_in = 3'd0; Store_in = 2'd0;
    ALUResult_in = 32'h0; MemWriteData_in = 32'h0;
    e_stall = 1'b0; e_req = 1'b0; e_ade = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    go_idle();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // rising edge that starts the IDLE cycle following the access.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] ld,
                        input logic [1:0] st, input logic [31:0] addr,
                        input logic [31:0] d, input logic [31:0] rdata, input int wt,
                        output int n_req, output int n_stall,
                        output logic [31:0] c_addr, output logic [31:0] c_wdata,
                        output logic [3:0] c_be, output logic c_we);
    logic ade;
    n_req = 0; n_stall = 0;
    c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0; c_we = 1'b0;
    MemRead_in = rd; MemWrite_in = wr; Load_in = ld; Store_in = st;
    ALUResult_in = addr; MemWriteData_in = d;
    ade = model_ade(rd, wr, ld, st, addr);
    e_ade = ade; e_req = 1'b0; e_stall = (rd | wr) & ~ade;
    #1;
    if (MEM_Stall) n_stall++;
    if (ade) begin
      @(posedge clk); #1;
      #1;
      if (dmem_req) n_req++;
      go_idle();
      return;
    end
    @(posedge clk); #1;
    e_req = 1'b1; e_stall = 1'b1; e_we = ~rd & wr;
    e_addr = addr & 32'hFFFFFFFC;
    e_be = model_be(rd, ld, st, addr);
    e_wdata = model_wdata(rd, st, d);
    #1;
    c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be; c_we = dmem_we;
    for (int i = 0; i <= wt; i++) begin
      if (i > 0) begin @(posedge clk); #1; #1; end
      if (dmem_req) n_req++;
      if (MEM_Stall) n_stall++;
      dmem_ack = (i == wt);
      dmem_rdata = (i == wt) ? rdata : 32'hA5A5A5A5;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h5A5AC3C3;
    e_req = 1'b0; e_stall = 1'b0;
    if (rd) e_ld = model_ext(ld, addr, rdata);
    @(posedge clk); #1;
    go_idle();
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    go_idle();
    e_we = 1'b0; e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0; e_ld = 32'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_req",   32'(dmem_req),  32'h0);
    check("rst_we",    32'(dmem_we),   32'h0);
    check("rst_addr",  dmem_addr,      32'h0);
    check("rst_be",    32'(dmem_be),   32'h0);
    check("rst_wdata", dmem_wdata,     32'h0);
    check("rst_load",  LoadData_o,     32'h0);
    check("rst_stall", 32'(MEM_Stall), 32'h0);
    rst = 1'b0;
    idle_cycles(2);

    // LW 0x100, two wait cycles
    run_op(1, 0, 3'd0, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 2, nr, ns, ca, cw, cb, cwe);
    check("lw_req_cycles", 32'(nr), 32'd3);
    check("lw_stall_cycles", 32'(ns), 32'd4);
    check("lw_addr", ca, 32'h100);
    check("lw_be", 32'(cb), 32'hF);
    check("lw_data", LoadData_o, 32'hDEADBEEF);
    idle_cycles(1);

    // LB / LBU at 0x103, immediate ack
    run_op(1, 0, 3'd1, 2'd0, 32'h103, 32'h0, 32'h80112233, 0, nr, ns, ca, cw, cb, cwe);
    check("lb_data", LoadData_o, 32'hFFFFFF80);
    check("lb_stall_cycles", 32'(ns), 32'd2);
    run_op(1, 0, 3'd2, 2'd0, 32'h103, 32'h0, 32'h80112233, 0, nr, ns, ca, cw, cb, cwe);
    check("lbu_data", LoadData_o, 32'h00000080);
    idle_cycles(1);

    // SH 0x0E
    run_op(0, 1, 3'd0, 2'd2, 32'h0E, 32'h0000ABCD, 32'h11111111, 1, nr, ns, ca, cw, cb, cwe);
    check("sh_we", 32'(cwe), 32'h1);
    check("sh_be", 32'(cb), 32'hC);
    check("sh_wdata", cw, 32'hABCDABCD);
    check("sh_addr", ca, 32'h0C);
    check("sh_keeps_load", LoadData_o, 32'h00000080);

    // SB 0x21 followed immediately by LHU 0x22
    run_op(0, 1, 3'd0, 2'd1, 32'h21, 32'h0000005A, 32'h0, 0, nr, ns, ca, cw, cb, cwe);
    check("sb_be", 32'(cb), 32'h2);
    check("sb_wdata", cw, 32'h5A5A5A5A);
    run_op(1, 0, 3'd4, 2'd0, 32'h22, 32'h0, 32'h9234_5678, 0, nr, ns, ca, cw, cb, cwe);
    check("lhu_data", LoadData_o, 32'h00009234);

    // LH sign extension, unknown load type as LW, store type 11 as SW
    run_op(1, 0, 3'd3, 2'd0, 32'h40, 32'h0, 32'h1234_8001, 1, nr, ns, ca, cw, cb, cwe);
    check("lh_data", LoadData_o, 32'hFFFF8001);
    run_op(1, 0, 3'd7, 2'd0, 32'h44, 32'h0, 32'hCAFEF00D, 0, nr, ns, ca, cw, cb, cwe);
    check("ld7_data", LoadData_o, 32'hCAFEF00D);
    run_op(0, 1, 3'd0, 2'd3, 32'h48, 32'h13579BDF, 32'h0, 0, nr, ns, ca, cw, cb, cwe);
    check("sw11_be", 32'(cb), 32'hF);
    check("sw11_wdata", cw, 32'h13579BDF);

    // Read and write together: read only
    run_op(1, 1, 3'd0, 2'd1, 32'h50, 32'hFFFFFFFF, 32'h0BADF00D, 0, nr, ns, ca, cw, cb, cwe);
    check("rw_we", 32'(cwe), 32'h0);
    check("rw_wdata", cw, 32'h0);
    check("rw_data", LoadData_o, 32'h0BADF00D);
    idle_cycles(1);

    // Misaligned LW 0x102
    run_op(1, 0, 3'd0, 2'd0, 32'h102, 32'h0, 32'h600DCAFE, 0, nr, ns, ca, cw, cb, cwe);
`ifdef MEM_ALIGN_CHECK_EN
    check("ade_no_req", 32'(nr), 32'd0);
    check("ade_no_stall", 32'(ns), 32'd0);
    check("ade_keeps_load", LoadData_o, 32'h0BADF00D);
`else
    check("fa_addr", ca, 32'h100);
    check("fa_data", LoadData_o, 32'h600DCAFE);
`endif
    idle_cycles(1);

    // Reset while BUSY, then a late ack
    MemRead_in = 1'b1; Load_in = 3'd0; ALUResult_in = 32'h60;
    e_stall = 1'b1; e_req = 1'b0;
    @(posedge clk); #1;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h60; e_be = 4'hF; e_wdata = 32'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    go_idle();
    e_ld = 32'h0;
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("rstb_req", 32'(dmem_req), 32'h0);
    check("rstb_load", LoadData_o, 32'h0);
    idle_cycles(2);
    check("rstb_after_req", 32'(dmem_req), 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
